// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//
// Shared types and constants for the data-memory arbiter that sits between
// the pipeline MEM stage (port P) and the external loader/debug engine
// (port E).
//
// Contents:
//   arb_state_t     - arbiter ownership state (pipeline-priority / E burst)
//   arb_grant_t     - one-hot-or-zero grant pair produced each cycle
//   ARB_STARVE_MAX  - default consecutive denied E cycles before E wins
//   ARB_BURST_MAX   - default cap on a locked E burst while P is waiting
//   cnt_width()     - register width needed to hold 0..max_val
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    // Ownership state of the memory port.
    //   ARB_S_PIPE : default, P has priority.
    //   ARB_S_EXT  : E held the port last cycle with e_lock set.
    typedef enum logic [0:0] {
        ARB_S_PIPE = 1'b0,
        ARB_S_EXT  = 1'b1
    } arb_state_t;

    // Grant pair; at most one bit is set in any cycle.
    typedef struct packed {
        logic p;
        logic e;
    } arb_grant_t;

    localparam int ARB_STARVE_MAX = 4;
    localparam int ARB_BURST_MAX  = 8;

    // Width of a counter that must represent every value in 0..max_val.
    // Never narrower than one bit, so degenerate parameters still elaborate.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Arbitrates the single-port data memory between the pipeline MEM stage (P)
// and an external loader/debug engine (E). Exactly one owner (or none) drives
// the memory address, write data and write enable in any cycle.
//
// Policy:
//   - P has priority, but once E has been denied STARVE_MAX consecutive
//     requesting cycles, E wins the next cycle.
//   - E may hold the port across cycles with e_lock (a burst). If P is waiting
//     when the burst has used BURST_MAX grants, P is forced in. With P idle
//     the burst may continue indefinitely.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   p_req     in   pipeline access request
//   p_we      in   pipeline access is a write
//   p_addr    in   pipeline address                      [ASIZE]
//   p_wdata   in   pipeline write data                   [DSIZE]
//   p_rdata   out  pipeline read data, same cycle        [DSIZE]
//   p_stall   out  pipeline request denied this cycle
//   e_req     in   external access request
//   e_we      in   external access is a write
//   e_lock    in   keep ownership on the following cycle
//   e_addr    in   external address                      [ASIZE]
//   e_wdata   in   external write data                   [DSIZE]
//   e_gnt     out  external access performed this cycle
//   e_rvalid  out  registered read data valid (grant + 1)
//   e_rdata   out  registered external read data         [DSIZE]
//   m_addr    out  memory address                        [ASIZE]
//   m_wdata   out  memory write data                     [DSIZE]
//   m_we      out  memory write enable (writes on rising edge)
//   m_rdata   in   memory read data, combinational       [DSIZE]
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ASIZE      = 16,
    parameter int DSIZE      = 16,
    parameter int STARVE_MAX = ARB_STARVE_MAX,
    parameter int BURST_MAX  = ARB_BURST_MAX
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             p_req,
    input  logic             p_we,
    input  logic [ASIZE-1:0] p_addr,
    input  logic [DSIZE-1:0] p_wdata,
    output logic [DSIZE-1:0] p_rdata,
    output logic             p_stall,

    input  logic             e_req,
    input  logic             e_we,
    input  logic             e_lock,
    input  logic [ASIZE-1:0] e_addr,
    input  logic [DSIZE-1:0] e_wdata,
    output logic             e_gnt,
    output logic             e_rvalid,
    output logic [DSIZE-1:0] e_rdata,

    output logic [ASIZE-1:0] m_addr,
    output logic [DSIZE-1:0] m_wdata,
    output logic             m_we,
    input  logic [DSIZE-1:0] m_rdata
);

    localparam int SW = cnt_width(STARVE_MAX);
    localparam int BW = cnt_width(BURST_MAX - 1);

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;   // consecutive denied E cycles, saturating
    logic [BW-1:0] burst_q, burst_d;     // E grants taken while in ARB_S_EXT
    arb_grant_t    gnt;
    logic          e_starved;
    logic          burst_capped;

    // -------------------------------------------------------------------------
    // State and counter register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_S_PIPE;
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: grant decision and memory steering
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of a combinational block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt          = '0;
        // The starvation override only bites while E is actually asking;
        // otherwise a starved-then-withdrawn E would stall P with nobody
        // using the memory.
        e_starved    = e_req && (starve_q >= STARVE_LIM);
        burst_capped = p_req && (burst_q == BURST_LAST);

        unique case (state_q)
            ARB_S_PIPE: begin
                gnt.p = p_req && !e_starved;
                gnt.e = e_req && !gnt.p;
            end
            ARB_S_EXT: begin
                gnt.e = e_req && !burst_capped;
                // P takes the port when forced in, or when E abandons its burst.
                gnt.p = p_req && !gnt.e;
            end
            default: gnt = '0;
        endcase

        e_gnt   = gnt.e;
        p_stall = p_req && !gnt.p;
        // A non-granted port's write enable never reaches memory.
        m_we    = (gnt.p && p_we) || (gnt.e && e_we);
        // Idle cycles park the address on P so its next read sees no glitch.
        m_addr  = gnt.e ? e_addr  : p_addr;
        m_wdata = gnt.e ? e_wdata : p_wdata;
        p_rdata = m_rdata;
    end

    // -------------------------------------------------------------------------
    // Next-state logic: ownership state and counters
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        burst_d  = burst_q;

        if (gnt.e) begin
            starve_d = '0;
        end else if (e_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end

        // Only a locked E grant keeps E in charge; anything else (lock or
        // request dropped, P forced in, idle) returns to pipeline priority.
        state_d = (gnt.e && e_lock) ? ARB_S_EXT : ARB_S_PIPE;

        // The grant that opens a burst is taken in ARB_S_PIPE and is not
        // counted, so the cap lands after BURST_MAX grants in total.
        // At BURST_LAST the count holds; it only releases E when P waits.
        if (state_d == ARB_S_PIPE) begin
            burst_d = '0;
        end else if ((state_q == ARB_S_EXT) && (burst_q != BURST_LAST)) begin
            burst_d = burst_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // E read-data register
    // -------------------------------------------------------------------------
    // NOTE: e_rdata is a single visible register, not a storage array, so it
    // is reset to a known value rather than left undefined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_rvalid <= 1'b0;
            e_rdata  <= '0;
        end else begin
            e_rvalid <= gnt.e && !e_we;
            if (gnt.e && !e_we) begin
                e_rdata <= m_rdata;
            end
        end
    end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural memory is attached to
// the m_* port. A reference model tracks ownership in plain terms (is E
// holding a locked run, how long is that run, how long has E been waiting)
// and keeps its own shadow copy of memory contents.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int BURST_MAX  = 8;

    logic        clk;
    logic        rst;
    logic        p_req, p_we;
    logic [15:0] p_addr, p_wdata, p_rdata;
    logic        p_stall;
    logic        e_req, e_we, e_lock;
    logic [15:0] e_addr, e_wdata, e_rdata;
    logic        e_gnt, e_rvalid;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic        m_we;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          md_hold;    // E granted last cycle with lock
    int          md_run;     // grants in the current locked run
    int          md_wait;    // consecutive denied E requests, capped
    logic        md_rvalid;
    logic [15:0] md_rdata;

    // Values observed at the most recent sample point
    logic        obs_egnt, obs_stall, obs_mwe;
    logic [15:0] obs_prdata;

    dmem_arbiter #(
        .ASIZE(16), .DSIZE(16), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr),
        .e_wdata(e_wdata), .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign m_rdata = mem[m_addr];
    always @(posedge clk) if (m_we) mem[m_addr] <= m_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_hold   = 1'b0;
        md_run    = 0;
        md_wait   = 0;
        md_rvalid = 1'b0;
        md_rdata  = '0;
    endtask

    // One clock cycle: drive inputs just after a rising edge, check the
    // combinational outputs at the falling edge, advance the model, then
    // check the registered E read outputs just after the next rising edge.
    task automatic cycle(input logic pr, input logic pw, input logic [15:0] pa,
                         input logic [15:0] pd, input logic er, input logic ew,
                         input logic el, input logic [15:0] ea, input logic [15:0] ed);
        logic        pg, eg, we;
        logic [15:0] addr, wd;
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        e_req = er; e_we = ew; e_lock = el; e_addr = ea; e_wdata = ed;
        @(negedge clk);
        if (!md_hold) begin
            pg = pr && !(er && (md_wait >= STARVE_MAX));
            eg = er && !pg;
        end else begin
            eg = er && !(pr && (md_run >= BURST_MAX));
            pg = pr && !eg;
        end
        we   = (pg && pw) || (eg && ew);
        addr = eg ? ea : pa;
        wd   = eg ? ed : pd;

        obs_egnt   = e_gnt;
        obs_stall  = p_stall;
        obs_mwe    = m_we;
        obs_prdata = p_rdata;

        chk("e_gnt",   e_gnt,   eg);
        chk("p_stall", p_stall, pr && !pg);
        chk("m_we",    m_we,    we);
        chk("m_addr",  m_addr,  addr);
        if (we)        chk("m_wdata", m_wdata, wd);
        if (pg && !pw) chk("p_rdata", p_rdata, ref_mem[pa]);

        if (eg)                             md_wait = 0;
        else if (er && md_wait < STARVE_MAX) md_wait++;
        if (eg && el) begin
            md_run  = md_hold ? md_run + 1 : 1;
            md_hold = 1'b1;
        end else begin
            md_hold = 1'b0;
            md_run  = 0;
        end
        md_rvalid = eg && !ew;
        if (eg && !ew) md_rdata = ref_mem[ea];
        if (we) ref_mem[addr] = wd;

        @(posedge clk);
        #1;
        chk("e_rvalid", e_rvalid, md_rvalid);
        if (md_rvalid) chk("e_rdata", e_rdata, md_rdata);
    endtask

    int          e_cnt, stall_cnt;
    logic        r_pr, r_pw, r_er, r_ew, r_el;
    logic [15:0] r_pa, r_pd, r_ea, r_ed;
    bit          lock_heavy;

    initial begin
        rst = 1'b0;
        p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
        e_req = 0; e_we = 0; e_lock = 0; e_addr = '0; e_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        mem[16'h0020]     = 16'h1234;
        ref_mem[16'h0020] = 16'h1234;
        model_reset();

        // Reset state
        #2;
        chk("rst_e_gnt",    e_gnt,    0);
        chk("rst_p_stall",  p_stall,  0);
        chk("rst_m_we",     m_we,     0);
        chk("rst_e_rvalid", e_rvalid, 0);
        chk("rst_e_rdata",  e_rdata,  0);
        #6 rst = 1'b1;
        @(posedge clk);
        #1;

        // P only: write then read back
        cycle(1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000);
        chk("p_wr_mwe",   obs_mwe,   1);
        chk("p_wr_stall", obs_stall, 0);
        cycle(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        chk("p_rd_data",  obs_prdata, 16'hBEEF);
        chk("p_rd_mwe",   obs_mwe,    0);
        chk("p_rd_stall", obs_stall,  0);

        // E only: registered read
        cycle(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000);
        chk("e_rd_gnt",    obs_egnt, 1);
        chk("e_rvalid_n1", e_rvalid, 1);
        chk("e_rdata_n1",  e_rdata,  16'h1234);
        cycle(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        chk("e_rvalid_n2", e_rvalid, 0);

        // Contention: P wins four cycles, E one, then P again
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 16'h0100 + 16'(i), 16'h0000, 1, 0, 0, 16'h0030, 16'h0000);
            chk($sformatf("cont_egnt_%0d", i),  obs_egnt,  i == 4);
            chk($sformatf("cont_stall_%0d", i), obs_stall, i == 4);
        end

        // Burst cap: P arrives at E's third grant
        e_cnt = 0;
        stall_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            cycle(k >= 3, 0, 16'h0200, 16'h0000, 1, 0, 1, 16'h0300 + 16'(k), 16'h0000);
            if (obs_egnt)  e_cnt++;
            if (obs_stall) stall_cnt++;
            if (k == 9) begin
                chk("burst_k9_egnt",  obs_egnt,  0);
                chk("burst_k9_stall", obs_stall, 0);
            end
        end
        chk("burst_e_grants", e_cnt,     8);
        chk("burst_stalls",   stall_cnt, 6);
        cycle(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);

        // Write isolation: P write held off while E reads
        cycle(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0050, 16'h0000);
        cycle(1, 1, 16'h0040, 16'hCAFE, 1, 0, 1, 16'h0051, 16'h0000);
        chk("iso_egnt",  obs_egnt,  1);
        chk("iso_mwe",   obs_mwe,   0);
        chk("iso_stall", obs_stall, 1);
        chk("iso_mem",   mem[16'h0040], 16'h0040 ^ 16'h5A5A);
        cycle(1, 1, 16'h0040, 16'hCAFE, 0, 0, 0, 16'h0000, 16'h0000);
        chk("iso_p_wr_mwe", obs_mwe, 1);
        cycle(1, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        chk("iso_p_rd", obs_prdata, 16'hCAFE);

        // Reset in the middle of a locked burst
        cycle(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0060, 16'h0000);
        cycle(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0061, 16'h0000);
        e_addr = 16'h0062;
        #1;
        chk("rst_mid_pre_egnt", e_gnt, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_rvalid",     e_rvalid, 0);
        chk("rst_mid_rdata",      e_rdata,  0);
        chk("rst_mid_egnt_pidle", e_gnt,    1);
        chk("rst_mid_mwe",        m_we,     0);
        p_req = 1'b1;
        #1;
        chk("rst_mid_stall",      p_stall,  0);
        chk("rst_mid_egnt_pbusy", e_gnt,    0);
        @(posedge clk);
        #1;
        chk("rst_mid_held_rvalid", e_rvalid, 0);
        rst = 1'b1;
        cycle(1, 0, 16'h0070, 16'h0000, 1, 0, 1, 16'h0063, 16'h0000);
        chk("rst_rel_stall", obs_stall, 0);
        chk("rst_rel_egnt",  obs_egnt,  0);

        // Randomized traffic, alternating between short and long E bursts
        for (int n = 0; n < 400; n++) begin
            lock_heavy = ((n / 50) % 2) == 1;
            r_pr = $urandom_range(0, 9) < 7;
            r_pw = $urandom_range(0, 9) < 4;
            r_er = $urandom_range(0, 9) < (lock_heavy ? 9 : 6);
            r_ew = $urandom_range(0, 9) < 4;
            r_el = lock_heavy ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 1) == 1);
            r_pa = 16'h0400 + 16'($urandom_range(0, 7));
            r_ea = 16'h0400 + 16'($urandom_range(0, 7));
            r_pd = 16'($urandom);
            r_ed = 16'($urandom);
            cycle(r_pr, r_pw, r_pa, r_pd, r_er, r_ew, r_el, r_ea, r_ed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (port P) and an external loader/debug engine (port E).
- Grants one owner per cycle and drives the memory address, write-data and write-enable from that owner.
- Asserts a stall to the pipeline whenever P is denied.
- Bounds E starvation and E burst length so that neither side can lock the other out.

Parameters:
- ASIZE, 16, address width (matches ISIZE).
- DSIZE, 16, data width.
- STARVE_MAX, 4, number of consecutive denied E cycles after which E wins over P.
- BURST_MAX, 8, maximum consecutive E grants under e_lock while P is waiting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- p_req  in  1  pipeline requests a memory access this cycle.
- p_we  in  1  pipeline access is a write.
- p_addr  in  ASIZE  pipeline address.
- p_wdata  in  DSIZE  pipeline write data.
- p_rdata  out  DSIZE  pipeline read data; same cycle as grant.
- p_stall  out  1  pipeline must hold its MEM stage and all earlier stages.
- e_req  in  1  external access request.
- e_we  in  1  external access is a write.
- e_lock  in  1  E requests to keep ownership on the following cycle (burst).
- e_addr  in  ASIZE  external address.
- e_wdata  in  DSIZE  external write data.
- e_gnt  out  1  E access performed this cycle.
- e_rvalid  out  1  registered read data valid; one cycle after an E read grant.
- e_rdata  out  DSIZE  registered E read data.
- m_addr  out  ASIZE  to memory address.
- m_wdata  out  DSIZE  to memory data_in.
- m_we  out  1  to memory write_en; memory writes on the rising edge.
- m_rdata  in  DSIZE  memory data_out; combinational read of m_addr.

Behaviour:
- State register, 2 states:
  - S_PIPE: default; P has priority.
  - S_EXT: E held the previous cycle with e_lock.
- Registered counters:
  - starve_cnt: 0..STARVE_MAX.
  - burst_cnt: 0..BURST_MAX-1.
- Grant, combinational from state, counters and requests:
  - S_PIPE: P granted if p_req and starve_cnt<STARVE_MAX. Otherwise E granted if e_req.
  - S_EXT: E granted if e_req, unless p_req and burst_cnt==BURST_MAX-1, in which case P is granted.
  - Idle cycle: neither granted; m_we=0 and m_addr=p_addr.
- p_stall = p_req & ~p_gnt.
- e_gnt = E granted.
- m_we = (p_gnt & p_we) | (e_gnt & e_we). The write-enable of a non-granted port never reaches memory.
- p_rdata = m_rdata, passed through combinationally; valid only when p_gnt & ~p_we.
- E reads: on e_gnt & ~e_we, e_rdata <= m_rdata and e_rvalid <= 1 at the next edge. Otherwise e_rvalid <= 0 and e_rdata holds its value.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when e_req & ~e_gnt.
  - Clears on e_gnt.
  - Holds when e_req=0.
- burst_cnt:
  - Increments on each e_gnt while in S_EXT.
  - Clears on entry to S_PIPE.
- Transitions:
  - S_PIPE -> S_EXT when e_gnt & e_lock.
  - S_EXT stays in S_EXT when e_gnt & e_lock and burst_cnt<BURST_MAX-1.
  - S_EXT stays in S_EXT (burst_cnt holds at BURST_MAX-1) when e_gnt & e_lock and burst_cnt==BURST_MAX-1 with p_req low. The cap releases E only when P is waiting.
  - S_EXT -> S_PIPE when e_lock drops, e_req drops, or P is force-granted.
- Simultaneous p_req & e_req:
  - P wins until starve_cnt reaches STARVE_MAX.
  - E then wins exactly one cycle, or a burst if e_lock is set.
- Reset (rst=0, asynchronous, may occur mid-burst):
  - state=S_PIPE; starve_cnt=0; burst_cnt=0; e_rvalid=0; e_rdata=0.
  - Combinational outputs follow the reset state immediately: e_gnt=0 unless P is idle and e_req is set; p_stall=0 whenever E is not starving.
  - No partial write carries across reset; m_we depends only on current grants.
- Latency:
  - P: 0 cycles; grant and data in the same cycle.
  - E: write completes at the grant edge; read data appears 1 cycle after grant.

Decomposition:
- Add to define.v: ARB_S_PIPE and ARB_S_EXT state encodings, plus default STARVE_MAX and BURST_MAX constants.
- No sub-module needed. Starve and burst counters are inline registers; the grant logic is one combinational block.

Test Plan:
- P only:
  - p_req=1, p_we=1, addr 0x0010, data 0xBEEF, then a read of 0x0010 -> m_we=1 for one cycle.
  - p_rdata=0xBEEF on the read cycle.
  - p_stall=0 throughout.
- E only:
  - e_req=1, e_we=0, addr 0x0020, with memory holding 0x1234 -> e_gnt=1 in cycle n.
  - e_rvalid=1 and e_rdata=0x1234 in cycle n+1.
  - e_rvalid=0 in cycle n+2.
- Contention with STARVE_MAX=4:
  - p_req and e_req both held high -> P granted cycles 0-3 with p_stall=0.
  - Cycle 4: e_gnt=1 and p_stall=1.
  - Cycle 5: P granted again; starve_cnt=1.
- Burst cap with BURST_MAX=8:
  - E locked burst; p_req rises at E's 3rd grant -> E granted 8 consecutive cycles.
  - P granted on the 9th cycle; p_stall high for exactly the intervening 6 cycles.
- Write isolation:
  - p_we=1 while E is granted for a read -> m_we=0.
  - Memory at p_addr is unchanged until P is granted.
- Reset mid-burst:
  - rst=0 in E's 3rd locked grant -> all counters and e_rvalid=0 immediately.
  - After release with p_req=1: P granted on the first cycle.
